// File: rtl/cart_bus_pkg.sv
// Shared definitions for the cartridge bus front end and the MBC sequencer.
package cart_bus_pkg;

  // Access qualification states of the bus snooper.
  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    ACTIVE
  } cart_bus_state_t;

  // Default trigger address nibbles: AddrLo[3:0] and AddrHi of the MBC trigger.
  localparam logic [3:0] MATCH_LO_DEFAULT = 4'h5;
  localparam logic [3:0] MATCH_HI_DEFAULT = 4'hA;

  // True when a 12-bit {hi, lo} address hits the trigger nibbles.
  function automatic logic addr_match(input logic [11:0] addr,
                                      input logic [3:0]  match_lo,
                                      input logic [3:0]  match_hi);
    return (addr[3:0] == match_lo) && (addr[11:8] == match_hi);
  endfunction

endpackage

// File: rtl/cart_bus_snoop_sync_ff.sv
// Multi-stage synchroniser for a bundle of asynchronous inputs; all stages clear to 0.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift each raw bit through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/cart_bus_snoop.sv
// Cartridge bus snooper: synchronises the async bus, filters glitches, publishes qualified
// read addresses with start/end pulses, counts accesses and arms on the MBC trigger address.
module cart_bus_snoop
  import cart_bus_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 2,
  parameter logic [3:0] MATCH_LO    = MATCH_LO_DEFAULT,
  parameter logic [3:0] MATCH_HI    = MATCH_HI_DEFAULT,
  parameter int         CNT_W       = 8
) (
  input  logic             SClk,
  input  logic             Reset,
  input  logic [7:0]       AddrLoIn,
  input  logic [3:0]       AddrHiIn,
  input  logic             nOE,
  input  logic             nSel,
  output logic [7:0]       AddrLo,
  output logic [3:0]       AddrHi,
  output logic             AccessStart,
  output logic             AccessEnd,
  output logic             MatchHit,
  output logic             Armed,
  output logic [CNT_W-1:0] AccessCount,
  output logic [CNT_W-1:0] GlitchCount
);

  localparam logic [4:0]       FILT    = 5'(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Strobes are inverted before synchronising so that the all-zero reset value of the
  // sync chain reads as "bus inactive" and cannot fake an access after reset.
  logic [13:0] raw;
  logic [13:0] synced;
  logic        act;
  logic [11:0] addr_s;

  assign raw    = {~nSel, ~nOE, AddrHiIn, AddrLoIn};
  assign act    = synced[13] & synced[12];
  assign addr_s = synced[11:0];

  sync_ff #(.WIDTH(14), .STAGES(SYNC_STAGES)) u_sync (
    .clk (SClk),
    .rst (Reset),
    .d   (raw),
    .q   (synced)
  );

  cart_bus_state_t  state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic [11:0]      cand, cand_next;
  logic [7:0]       lo_next;
  logic [3:0]       hi_next;
  logic             start_next, end_next, match_next, armed_next;
  logic [CNT_W-1:0] acc_next, glitch_next;
  logic             qualify;
  logic [11:0]      qual_addr;
  logic [4:0]       cnt_inc;

  assign cnt_inc = {1'b0, cnt} + 5'd1;

  // State, filter and output registers.
  always_ff @(posedge SClk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      AddrLo      <= '0;
      AddrHi      <= '0;
      AccessStart <= 1'b0;
      AccessEnd   <= 1'b0;
      MatchHit    <= 1'b0;
      Armed       <= 1'b0;
      AccessCount <= '0;
      GlitchCount <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      cand        <= cand_next;
      AddrLo      <= lo_next;
      AddrHi      <= hi_next;
      AccessStart <= start_next;
      AccessEnd   <= end_next;
      MatchHit    <= match_next;
      Armed       <= armed_next;
      AccessCount <= acc_next;
      GlitchCount <= glitch_next;
    end
  end

  // Next-state logic: qualify stable reads, detect release and back-to-back address changes.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    cand_next   = cand;
    lo_next     = AddrLo;
    hi_next     = AddrHi;
    start_next  = 1'b0;
    end_next    = 1'b0;
    match_next  = 1'b0;
    armed_next  = Armed;
    acc_next    = AccessCount;
    glitch_next = GlitchCount;
    qualify     = 1'b0;
    qual_addr   = cand;

    case (state)
      IDLE: begin
        if (act) begin
          state_next = QUALIFY;
          cnt_next   = 4'd1;
          cand_next  = addr_s;
          if (FILT == 5'd1) begin
            qualify   = 1'b1;
            qual_addr = addr_s;
          end
        end
      end
      QUALIFY: begin
        if (!act) begin
          state_next = IDLE;
          if (!(&GlitchCount)) glitch_next = GlitchCount + CNT_ONE;
        end else if (addr_s != cand) begin
          cand_next = addr_s;
          cnt_next  = 4'd1;
          if (FILT == 5'd1) begin
            qualify   = 1'b1;
            qual_addr = addr_s;
          end
        end else begin
          cnt_next = cnt_inc[3:0];
          if (cnt_inc >= FILT) begin
            qualify   = 1'b1;
            qual_addr = cand;
          end
        end
      end
      ACTIVE: begin
        if (!act) begin
          state_next = IDLE;
          end_next   = 1'b1;
        end else if (addr_s != {AddrHi, AddrLo}) begin
          // Strobes held while the address moved: close this read, start qualifying the next.
          state_next = QUALIFY;
          end_next   = 1'b1;
          cand_next  = addr_s;
          cnt_next   = 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (qualify) begin
      state_next = ACTIVE;
      lo_next    = qual_addr[7:0];
      hi_next    = qual_addr[11:8];
      start_next = 1'b1;
      if (!(&AccessCount)) acc_next = AccessCount + CNT_ONE;
      match_next = addr_match(qual_addr, MATCH_LO, MATCH_HI);
      if (match_next) armed_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_cart_bus_snoop.sv
// Self-checking bench for cart_bus_snoop: hand table for a clean read, directed corner
// sequences and a randomized run, all compared every cycle against a run-length reference model.
module tb_cart_bus_snoop;

  localparam int S      = 2;
  localparam int FL     = 2;
  localparam int SATMAX = 255;

  logic       SClk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] AddrLoIn = 8'h00;
  logic [3:0] AddrHiIn = 4'h0;
  logic       nOE = 1'b1;
  logic       nSel = 1'b1;
  logic [7:0] AddrLo;
  logic [3:0] AddrHi;
  logic       AccessStart, AccessEnd, MatchHit, Armed;
  logic [7:0] AccessCount, GlitchCount;

  cart_bus_snoop dut (
    .SClk(SClk), .Reset(Reset), .AddrLoIn(AddrLoIn), .AddrHiIn(AddrHiIn),
    .nOE(nOE), .nSel(nSel), .AddrLo(AddrLo), .AddrHi(AddrHi),
    .AccessStart(AccessStart), .AccessEnd(AccessEnd), .MatchHit(MatchHit),
    .Armed(Armed), .AccessCount(AccessCount), .GlitchCount(GlitchCount)
  );

  always #5 SClk = ~SClk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_no = 0;

  // Reference model: raw samples delayed S edges, then a run-length view of the bus.
  bit          p_act [S];
  logic [11:0] p_addr [S];
  bit          m_in;
  logic [11:0] m_addr;
  int          m_run;
  logic [11:0] m_run_addr;
  int          m_acc, m_gl;
  bit          m_armed, e_start, e_end, e_match;

  int start_q[$];
  int end_q[$];
  int match_q[$];

  typedef struct {
    logic [7:0] lo;
    logic [3:0] hi;
    logic       noe;
    logic       nsel;
    logic [3:0] exp;  // {start, end, match, armed}
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      p_act[i]  = 1'b0;
      p_addr[i] = '0;
    end
    m_in = 0; m_addr = '0; m_run = 0; m_run_addr = '0;
    m_acc = 0; m_gl = 0; m_armed = 0;
    e_start = 0; e_end = 0; e_match = 0;
  endtask

  task automatic model_begin_access();
    m_in    = 1;
    m_addr  = m_run_addr;
    m_run   = 0;
    e_start = 1;
    m_acc   = (m_acc < SATMAX) ? m_acc + 1 : SATMAX;
    e_match = (m_run_addr[3:0] == 4'h5) && (m_run_addr[11:8] == 4'hA);
    if (e_match) m_armed = 1;
  endtask

  task automatic model_step(input logic [7:0] lo, input logic [3:0] hi, input logic noe,
                            input logic nsel);
    bit          seen_act;
    logic [11:0] seen_addr;
    seen_act  = p_act[S-1];
    seen_addr = p_addr[S-1];
    for (int i = S - 1; i > 0; i--) begin
      p_act[i]  = p_act[i-1];
      p_addr[i] = p_addr[i-1];
    end
    p_act[0]  = !noe && !nsel;
    p_addr[0] = {hi, lo};
    e_start = 0; e_end = 0; e_match = 0;
    if (m_in) begin
      if (!seen_act) begin
        e_end = 1; m_in = 0; m_run = 0;
      end else if (seen_addr != m_addr) begin
        e_end = 1; m_in = 0; m_run = 1; m_run_addr = seen_addr;
      end
    end else if (!seen_act) begin
      if (m_run > 0) m_gl = (m_gl < SATMAX) ? m_gl + 1 : SATMAX;
      m_run = 0;
    end else begin
      if (m_run > 0 && seen_addr == m_run_addr) m_run++;
      else begin
        m_run = 1; m_run_addr = seen_addr;
      end
      if (m_run >= FL) model_begin_access();
    end
  endtask

  // One bus cycle: drive at the falling edge, step the model at the rising edge, compare after.
  task automatic cyc(input logic [7:0] lo, input logic [3:0] hi, input logic noe,
                     input logic nsel);
    AddrLoIn = lo; AddrHiIn = hi; nOE = noe; nSel = nsel;
    @(posedge SClk);
    model_step(lo, hi, noe, nsel);
    @(negedge SClk);
    cyc_no++;
    check("model", {AddrHi, AddrLo, 1'b0, AccessStart, AccessEnd, MatchHit, Armed,
                    AccessCount, GlitchCount},
          {m_addr[11:8], m_addr[7:0], 1'b0, e_start, e_end, e_match, m_armed,
           8'(m_acc), 8'(m_gl)});
    if (AccessStart) start_q.push_back(cyc_no);
    if (AccessEnd)   end_q.push_back(cyc_no);
    if (MatchHit)    match_q.push_back(cyc_no);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(AddrLoIn, AddrHiIn, 1'b1, 1'b1);
  endtask

  task automatic clear_tally();
    start_q.delete(); end_q.delete(); match_q.delete();
  endtask

  initial begin
    logic [11:0] addr, prev_addr;
    int hold, gap, n_end_before;

    tbl[0] = '{8'h05, 4'hA, 1'b0, 1'b0, 4'b0000};
    tbl[1] = '{8'h05, 4'hA, 1'b0, 1'b0, 4'b0000};
    tbl[2] = '{8'h05, 4'hA, 1'b0, 1'b0, 4'b0000};
    tbl[3] = '{8'h05, 4'hA, 1'b0, 1'b0, 4'b1011};
    tbl[4] = '{8'h05, 4'hA, 1'b0, 1'b0, 4'b0001};
    tbl[5] = '{8'h05, 4'hA, 1'b0, 1'b0, 4'b0001};
    tbl[6] = '{8'h05, 4'hA, 1'b1, 1'b0, 4'b0001};
    tbl[7] = '{8'h05, 4'hA, 1'b1, 1'b0, 4'b0001};
    tbl[8] = '{8'h05, 4'hA, 1'b1, 1'b0, 4'b0101};
    tbl[9] = '{8'h05, 4'hA, 1'b1, 1'b1, 4'b0001};

    // Power-on reset.
    model_reset();
    repeat (3) @(negedge SClk);
    check("reset_state", {AddrHi, AddrLo, AccessStart, AccessEnd, MatchHit, Armed,
                          AccessCount, GlitchCount}, 32'd0);
    Reset = 1'b0;

    // 1: reset asserted while ACTIVE, strobes released during reset.
    for (int i = 0; i < 5; i++) cyc(8'h33, 4'h3, 1'b0, 1'b0);
    check("pre_reset_count", {24'd0, AccessCount}, 32'd1);
    Reset = 1'b1; nOE = 1'b1; nSel = 1'b1;
    #1;
    model_reset();
    check("async_reset", {AddrHi, AddrLo, AccessStart, AccessEnd, MatchHit, Armed,
                          AccessCount, GlitchCount}, 32'd0);
    repeat (2) @(negedge SClk);
    Reset = 1'b0;
    clear_tally();
    idle(6);
    check("no_end_after_reset", 32'(end_q.size()), 32'd0);
    check("post_reset_zero", {AddrHi, AddrLo, Armed, AccessCount, GlitchCount}, 32'd0);

    // 3: single-cycle nOE glitch.
    clear_tally();
    cyc(8'h05, 4'hA, 1'b0, 1'b0);
    idle(5);
    check("glitch_count", {24'd0, GlitchCount}, 32'd1);
    check("glitch_no_start", 32'(start_q.size()), 32'd0);
    check("glitch_not_armed", {31'd0, Armed}, 32'd0);

    // 2: clean read of 0xA..05, table driven.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].lo, tbl[i].hi, tbl[i].noe, tbl[i].nsel);
      $display("vec %0d: lo=%h hi=%h nOE=%b nSel=%b -> start/end/match/armed=%b", i,
               tbl[i].lo, tbl[i].hi, tbl[i].noe, tbl[i].nsel,
               {AccessStart, AccessEnd, MatchHit, Armed});
      check("tbl_pulses", {28'd0, AccessStart, AccessEnd, MatchHit, Armed},
            {28'd0, tbl[i].exp});
    end
    check("clean_count", {24'd0, AccessCount}, 32'd1);
    check("clean_addr", {20'd0, AddrHi, AddrLo}, {20'd0, 12'hA05});

    // 4: address settles during QUALIFY.
    clear_tally();
    idle(2);
    cyc(8'h00, 4'h6, 1'b0, 1'b0);
    cyc(8'h15, 4'h6, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(8'hA5, 4'h6, 1'b0, 1'b0);
    idle(4);
    check("settle_starts", 32'(start_q.size()), 32'd1);
    check("settle_addr", {20'd0, AddrHi, AddrLo}, {20'd0, 12'h6A5});

    // 5: back-to-back reads with strobes held.
    clear_tally();
    idle(2);
    for (int i = 0; i < 5; i++) cyc(8'h10, 4'hA, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(8'h05, 4'hA, 1'b0, 1'b0);
    idle(4);
    check("b2b_starts", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2 && end_q.size() >= 1) begin
      check("b2b_end_between", {31'd0, (end_q[0] > start_q[0]) && (end_q[0] < start_q[1])},
            32'd1);
      check("b2b_match_second", {31'd0, (match_q.size() == 1) && (match_q[0] == start_q[1])},
            32'd1);
    end else begin
      check("b2b_end_between", 32'(end_q.size()), 32'd1);
    end

    // 6: randomized reads until the access counter saturates.
    prev_addr = 12'hFFF;
    for (int r = 0; r < 300; r++) begin
      addr = (r % 10 == 0) ? 12'hA05 : 12'($urandom);
      gap  = $urandom_range(0, 3);
      if (gap == 0 && addr == prev_addr) addr = addr ^ 12'h001;
      hold = $urandom_range(2, 5);
      for (int i = 0; i < hold; i++) cyc(addr[7:0], addr[11:8], 1'b0, 1'b0);
      for (int i = 0; i < gap; i++) begin
        case ($urandom_range(0, 7))
          0:       cyc(addr[7:0], addr[11:8], 1'b0, 1'b1);
          1:       cyc(8'($urandom), 4'($urandom), 1'b1, 1'b0);
          default: cyc(addr[7:0], addr[11:8], 1'b1, 1'b1);
        endcase
      end
      if (gap > 0 && $urandom_range(0, 9) == 0) begin
        cyc(8'($urandom), 4'($urandom), 1'b0, 1'b0);
        idle(2);
        prev_addr = 12'hFFF;
      end else begin
        prev_addr = (gap == 0) ? addr : 12'hFFF;
      end
    end
    idle(4);
    check("acc_saturated", {24'd0, AccessCount}, 32'd255);
    check("armed_sticky", {31'd0, Armed}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
